// File: rtl/mult_stream_pkg.sv
// Shared types and default parameters for the streaming multiplier block.
package mult_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_e;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_SETTLE = 1;

endpackage

// File: rtl/mult_stream_op_fifo.sv
// Operand-pair queue: circular buffer with occupancy count and a
// combinational head output.
module op_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [2*WIDTH-1:0]       din,
  input  logic                     pop,
  output logic [2*WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Never overrun or underrun, whatever the caller asks for.
  assign do_push = push && (level != LW'(DEPTH));
  assign do_pop  = pop  && (level != '0);
  assign dout    = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; occupancy and pointers decide
  // what is valid, and leaving the array out of reset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/multiply.sv
// Combinational unsigned multiply core: full-width product of two operands.
module multiply #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   iX,
  input  logic [WIDTH-1:0]   iY,
  output logic [2*WIDTH-1:0] oO
);

  assign oO = {{WIDTH{1'b0}}, iX} * {{WIDTH{1'b0}}, iY};

endmodule

// File: rtl/mult_stream.sv
// Streaming multiplier: queues operand pairs, gives the combinational core
// SETTLE cycles per pair, and presents registered products with valid/ready.
module mult_stream
  import mult_stream_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic [WIDTH-1:0]       iA,
  input  logic [WIDTH-1:0]       iB,
  input  logic                   iValid,
  output logic                   oReady,
  output logic [2*WIDTH-1:0]     oResult,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [$clog2(DEPTH):0] oLevel
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e             state;
  state_e             state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   rx;
  logic [WIDTH-1:0]   ry;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] head;
  logic               push;
  logic               pop;
  logic               capture;
  logic               release_res;
  logic               has_op;

  assign oReady = (oLevel < LW'(DEPTH)) && !iRst;
  assign push   = iValid && oReady;
  assign has_op = (oLevel != '0);

  op_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (iClk),
    .rst   (iRst),
    .push  (push),
    .din   ({iA, iB}),
    .pop   (pop),
    .dout  (head),
    .level (oLevel)
  );

  multiply #(WIDTH) u_mul (
    .iX (rx),
    .iY (ry),
    .oO (prod)
  );

  always_ff @(posedge iClk) begin
    if (iRst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every always_comb output is given a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (has_op) state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt == '0) state_nxt = ST_HOLD;
      ST_HOLD:   if (iReady) state_nxt = has_op ? ST_SETTLE : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    unique case (state)
      ST_IDLE:   pop = has_op;
      ST_SETTLE: capture = (cnt == '0);
      ST_HOLD: begin
        release_res = iReady;
        pop         = iReady && has_op;
      end
      default: ;
    endcase
  end

  // Operand registers, settle counter and result register.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rx      <= '0;
      ry      <= '0;
      cnt     <= '0;
      oResult <= '0;
      oValid  <= 1'b0;
    end else begin
      if (pop) begin
        rx  <= head[2*WIDTH-1:WIDTH];
        ry  <= head[WIDTH-1:0];
        cnt <= CW'(SETTLE - 1);
      end else if (state == ST_SETTLE && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (capture) begin
        oResult <= prod;
        oValid  <= 1'b1;
      end else if (release_res) begin
        oValid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_stream.sv
// Self-checking bench for mult_stream: directed vectors, backpressure,
// randomized scoreboard traffic, SETTLE=2 throughput and mid-flight reset.
module tb_mult_stream;

  logic       clk = 1'b0;
  logic       rst;
  // Instance 1: SETTLE=1
  logic [3:0] a1, b1;
  logic       iv1, ir1, ordy1, ov1;
  logic [7:0] res1;
  logic [2:0] lvl1;
  // Instance 2: SETTLE=2
  logic [3:0] a2, b2;
  logic       iv2, ir2, ordy2, ov2;
  logic [7:0] res2;
  logic [2:0] lvl2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int q1[$];
  int q2[$];
  int ndel1, ndel2, last2;
  logic acc1, acc2;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] y;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  mult_stream #(.WIDTH(4), .DEPTH(4), .SETTLE(1)) dut1 (
    .iClk(clk), .iRst(rst), .iA(a1), .iB(b1), .iValid(iv1), .oReady(ordy1),
    .oResult(res1), .oValid(ov1), .iReady(ir1), .oLevel(lvl1)
  );

  mult_stream #(.WIDTH(4), .DEPTH(4), .SETTLE(2)) dut2 (
    .iClk(clk), .iRst(rst), .iA(a2), .iB(b2), .iValid(iv2), .oReady(ordy2),
    .oResult(res2), .oValid(ov2), .iReady(ir2), .oLevel(lvl2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int prod(input logic [3:0] a, input logic [3:0] b);
    return int'(a) * int'(b);
  endfunction

  // Samples handshakes in mid-cycle, keeps the reference queues, then
  // advances to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    acc1 = iv1 && ordy1;
    acc2 = iv2 && ordy2;
    check("ready_rule", int'(ordy1), int'((lvl1 < 3'd4) && !rst));
    check("level_bound", int'(lvl1 <= 3'd4), 1);
    if (rst) begin
      q1.delete();
      q2.delete();
    end else begin
      if (acc1) q1.push_back(prod(a1, b1));
      if (acc2) q2.push_back(prod(a2, b2));
      if (ov1 && ir1) begin
        if (q1.size() == 0) check("unexpected_result1", int'(res1), -1);
        else                check("result1_order", int'(res1), q1.pop_front());
        ndel1++;
      end
      if (ov2 && ir2) begin
        if (q2.size() == 0) check("unexpected_result2", int'(res2), -1);
        else                check("result2_order", int'(res2), q2.pop_front());
        if (ndel2 > 0) check("throughput_period", cyc - last2, 3);
        last2 = cyc;
        ndel2++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int k, budget;
    logic [7:0] held;
    logic [3:0] pa[6], pb[6];

    vecs[0] = '{4'b0101, 4'b1100, 8'd60};
    vecs[1] = '{4'd15, 4'd15, 8'd225};
    vecs[2] = '{4'd0,  4'd9,  8'd0};
    vecs[3] = '{4'd1,  4'd1,  8'd1};
    vecs[4] = '{4'd15, 4'd1,  8'd15};
    vecs[5] = '{4'd8,  4'd8,  8'd64};
    vecs[6] = '{4'd7,  4'd9,  8'd63};

    rst = 1'b1;
    a1 = '0; b1 = '0; iv1 = 1'b0; ir1 = 1'b1;
    a2 = '0; b2 = '0; iv2 = 1'b0; ir2 = 1'b1;
    ndel1 = 0; ndel2 = 0; last2 = 0;

    // Reset state
    repeat (2) tick();
    check("rst_ready", int'(ordy1), 0);
    check("rst_valid", int'(ov1), 0);
    check("rst_level", int'(lvl1), 0);
    check("rst_result", int'(res1), 0);
    rst = 1'b0;
    #1;
    check("ready_after_release", int'(ordy1), 1);

    // Directed vectors: latency SETTLE+1 and exact products
    foreach (vecs[i]) begin
      a1 = vecs[i].a; b1 = vecs[i].b; iv1 = 1'b1;
      tick();
      iv1 = 1'b0;
      check("level_after_accept", int'(lvl1), 1);
      check("valid_early", int'(ov1), 0);
      tick();
      check("valid_at_1", int'(ov1), 0);
      tick();
      check("valid_at_2", int'(ov1), 1);
      check("vec_product", int'(res1), int'(vecs[i].y));
      tick();
      check("valid_released", int'(ov1), 0);
    end

    // Backpressure: 6 pairs offered, 5 fit
    ir1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pa[i] = 4'($urandom_range(0, 15));
      pb[i] = 4'($urandom_range(0, 15));
    end
    k = 0;
    for (int c = 0; c < 12; c++) begin
      iv1 = (k < 6);
      if (k < 6) begin a1 = pa[k]; b1 = pb[k]; end
      tick();
      if (acc1) k++;
    end
    check("bp_accepted", k, 5);
    check("bp_level", int'(lvl1), 4);
    check("bp_ready", int'(ordy1), 0);
    check("bp_valid", int'(ov1), 1);
    check("bp_head_result", int'(res1), prod(pa[0], pb[0]));
    held = res1;
    repeat (3) begin
      tick();
      check("bp_stable", int'(res1), int'(held));
    end
    iv1 = 1'b0;
    ir1 = 1'b1;
    ndel1 = 0;
    budget = 0;
    while (ndel1 < 5 && budget < 40) begin
      tick();
      budget++;
    end
    check("bp_drained", ndel1, 5);

    // Randomized traffic against the scoreboard
    for (int c = 0; c < 400; c++) begin
      iv1 = ($urandom_range(0, 1) == 1);
      ir1 = ($urandom_range(0, 9) < 7);
      a1  = 4'($urandom_range(0, 15));
      b1  = 4'($urandom_range(0, 15));
      tick();
    end
    iv1 = 1'b0;
    ir1 = 1'b1;
    budget = 0;
    while ((q1.size() != 0 || ov1) && budget < 60) begin
      tick();
      budget++;
    end
    check("random_drained", q1.size(), 0);

    // SETTLE=2 instance: 8 pairs back-to-back, one product per 3 cycles
    k = 0;
    budget = 0;
    while (ndel2 < 8 && budget < 80) begin
      iv2 = (k < 8);
      a2  = 4'($urandom_range(0, 15));
      b2  = 4'($urandom_range(0, 15));
      tick();
      if (acc2) k++;
      budget++;
    end
    iv2 = 1'b0;
    check("thru_delivered", ndel2, 8);

    // Reset while in SETTLE with 3 pairs queued
    ir1 = 1'b0;
    k = 0;
    budget = 0;
    while (k < 4 && budget < 20) begin
      iv1 = 1'b1;
      a1 = 4'($urandom_range(1, 15));
      b1 = 4'($urandom_range(1, 15));
      tick();
      if (acc1) k++;
      budget++;
    end
    iv1 = 1'b0;
    check("mid_level_before", int'(lvl1), 3);
    check("mid_valid_before", int'(ov1), 1);
    ir1 = 1'b1;
    iv1 = 1'b1;
    a1 = 4'd3; b1 = 4'd5;
    tick();
    iv1 = 1'b0;
    check("mid_level_settle", int'(lvl1), 3);
    check("mid_valid_settle", int'(ov1), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_valid", int'(ov1), 0);
    check("post_rst_level", int'(lvl1), 0);
    check("post_rst_ready", int'(ordy1), 1);
    repeat (10) begin
      tick();
      check("no_stale_valid", int'(ov1), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_stream.md
MULT_STREAM -- requirements
Module: mult_stream

Interface
REQ-001: Parameter WIDTH, default 4, operand width passed to the multiply core.
REQ-002: Parameter DEPTH, default 4, operand FIFO entries; power of two, >= 2.
REQ-003: Parameter SETTLE, default 1, cycles allowed for the combinational product to settle; >= 1.
REQ-004: iClk  in  1  single clock; all state updates on the rising edge.
REQ-005: iRst  in  1  synchronous, active-high reset.
REQ-006: iA  in  WIDTH  operand X.
REQ-007: iB  in  WIDTH  operand Y.
REQ-008: iValid  in  1  operand pair present.
REQ-009: oReady  out  1  block can accept an operand pair.
REQ-010: oResult  out  2*WIDTH  registered product.
REQ-011: oValid  out  1  oResult holds a valid product.
REQ-012: iReady  in  1  downstream accepts oResult.
REQ-013: oLevel  out  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014: An operand pair is accepted on an edge where iValid && oReady; it is written at the FIFO write pointer and oLevel increments.
REQ-015: oReady = (oLevel < DEPTH) && !iRst, derived combinationally from registered state; a same-cycle pop does not raise oReady when full.
REQ-016: Pointers wrap modulo DEPTH; push and pop in the same cycle leave oLevel unchanged.
REQ-017: FSM states IDLE, SETTLE, HOLD.
REQ-018: IDLE: if oLevel > 0, pop the head into operand registers rX/rY, load the settle counter with SETTLE-1 and go to SETTLE; otherwise stay.
REQ-019: SETTLE: rX/rY drive the multiply core (iX, iY, oO); when the counter is 0, register oO into oResult, set oValid, go to HOLD; otherwise decrement.
REQ-020: HOLD: oResult and oValid stay stable while !iReady; on iReady, if oLevel > 0 pop the next pair and go straight to SETTLE (oValid low for that cycle), else clear oValid and go to IDLE.
REQ-021: Latency from the accept edge into an empty, IDLE block to oValid high is SETTLE+1 cycles.
REQ-022: Sustained throughput with iReady held high is one product per SETTLE+1 cycles.
REQ-023: Products are unsigned and exactly 2*WIDTH bits; no truncation or saturation.
REQ-024: Results leave in the same order operands were accepted.
REQ-025: A pop never occurs when oLevel = 0, and a push never occurs when oLevel = DEPTH.

Reset
REQ-026: While iRst is high at an edge: state goes to IDLE; pointers, oLevel, counter, rX, rY and oResult are cleared; oValid = 0.
REQ-027: A reset mid-operation discards all queued and in-flight pairs with no partial output.
REQ-028: oReady is 0 during reset and 1 on the first cycle after release.

Structure
REQ-029: Package mult_stream_pkg holds the FSM state enum and the default parameter constants.
REQ-030: The operand queue is one sub-module, op_fifo (parameters WIDTH, DEPTH; push/pop/level ports).
REQ-031: The existing multiply core is instantiated once as multiply #(WIDTH) with ports iX, iY and oO; it is not modified.

Verification
REQ-032: iA=4'b0101, iB=4'b1100, iReady=1, SETTLE=1 -> oResult=8'b00111100 (60), with oValid high 2 cycles after the accept edge.
REQ-033: iA=15, iB=15 -> oResult=225; iA=0, iB=9 -> oResult=0.
REQ-034: iReady=0 while 6 pairs are offered -> 5 pairs are accepted (1 in rX/rY, 4 queued), oLevel=4, oReady=0 and oResult is stable; raising iReady drains 5 products in order.
REQ-035: 8 pairs back-to-back with iReady=1 and SETTLE=2 -> one product every 3 cycles, all correct and in order.
REQ-036: iRst pulsed for 1 cycle while in SETTLE with 3 pairs queued -> oValid=0, oLevel=0 and oReady=1 the next cycle; no stale product ever appears.
